// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges ALU and load results into the single regfile write port
// Load results wait in a small FIFO; ALU results always win the write port.
module regfile_writeback #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [N-1:0] alu_data,
  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [4:0]   mem_rd,
  input  logic [N-1:0] mem_data,
  output logic [4:0]   rd,
  output logic [N-1:0] write_data,
  output logic         write_enable,
  output logic [31:0]  pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic         ent_live_q [DEPTH];
  logic         ent_live_d [DEPTH];
  logic [4:0]   ent_rd_q   [DEPTH];
  logic [4:0]   ent_rd_d   [DEPTH];
  logic [N-1:0] ent_data_q [DEPTH];
  logic [N-1:0] ent_data_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [4:0]    rd_q, rd_d;
  logic [N-1:0]  write_data_q, write_data_d;
  logic          write_enable_q, write_enable_d;
  logic          push, pop, squash;

  assign mem_ready    = !rst && (count_q < FULL);
  assign rd           = rd_q;
  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;

  // live is cleared on pop, so a live entry is always an occupied one
  always_comb begin
    pending_mask = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_live_q[e]) pending_mask[ent_rd_q[e]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_comb begin
    push   = mem_valid && mem_ready;
    pop    = !alu_valid && (count_q != '0);
    squash = alu_valid && (alu_rd != 5'd0);
    for (int e = 0; e < DEPTH; e++) begin
      ent_live_d[e] = ent_live_q[e];
      ent_rd_d[e]   = ent_rd_q[e];
      ent_data_d[e] = ent_data_q[e];
    end
    rd_d           = rd_q;
    write_data_d   = write_data_q;
    write_enable_d = 1'b0;

    if (alu_valid) begin
      rd_d           = alu_rd;
      write_data_d   = alu_data;
      write_enable_d = squash;
    end else if (pop) begin
      rd_d               = ent_rd_q[rptr_q];
      write_data_d       = ent_data_q[rptr_q];
      write_enable_d     = ent_live_q[rptr_q];
      ent_live_d[rptr_q] = 1'b0;
    end

    // the ALU result is younger than every load queued or arriving now
    for (int e = 0; e < DEPTH; e++) begin
      if (squash && (ent_rd_q[e] == alu_rd)) ent_live_d[e] = 1'b0;
    end

    if (push) begin
      ent_live_d[wptr_q] = (mem_rd != 5'd0) && !(squash && (mem_rd == alu_rd));
      ent_rd_d[wptr_q]   = mem_rd;
      ent_data_d[wptr_q] = mem_data;
    end

    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      rd_q           <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_live_q[e] <= 1'b0;
        ent_rd_q[e]   <= '0;
        ent_data_q[e] <= '0;
      end
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      rd_q           <= rd_d;
      write_data_q   <= write_data_d;
      write_enable_q <= write_enable_d;
      for (int e = 0; e < DEPTH; e++) begin
        ent_live_q[e] <= ent_live_d[e];
        ent_rd_q[e]   <= ent_rd_d[e];
        ent_data_q[e] <= ent_data_d[e];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
// Directed scenarios followed by random traffic, both checked against a queue-based model.
module tb_regfile_writeback;
  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_valid = 1'b0;
  logic [4:0]   alu_rd = '0;
  logic [N-1:0] alu_data = '0;
  logic         mem_valid = 1'b0;
  logic         mem_ready;
  logic [4:0]   mem_rd = '0;
  logic [N-1:0] mem_data = '0;
  logic [4:0]   rd;
  logic [N-1:0] write_data;
  logic         write_enable;
  logic [31:0]  pending_mask;

  regfile_writeback #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rd(rd), .write_data(write_data), .write_enable(write_enable),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_we;
  logic        m_init = 1'b0;
  logic [31:0] dut_rf [32];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    logic        exp_ready;
    logic        push;
    logic [31:0] msk;
    ent_t        ne;
    rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    #1;
    exp_ready = !r && (q.size() < DEPTH);
    check("mem_ready", {63'd0, mem_ready}, {63'd0, exp_ready});
    if (m_init) begin
      msk = '0;
      foreach (q[i]) if (q[i].live) msk[q[i].rd] = 1'b1;
      check("pending_mask", {32'd0, pending_mask}, {32'd0, msk});
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rd = '0; m_wd = '0; m_we = 1'b0; m_init = 1'b1;
    end else begin
      push = mv && exp_ready;
      if (av) begin
        m_rd = ar; m_wd = ad; m_we = (ar != 5'd0);
        if (ar != 5'd0) foreach (q[i]) if (q[i].rd == ar) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        ne = q.pop_front();
        m_rd = ne.rd; m_wd = ne.data; m_we = ne.live;
      end else begin
        m_we = 1'b0;
      end
      if (push) begin
        ne.live = (mr != 5'd0) && !(av && (mr == ar));
        ne.rd = mr; ne.data = md;
        q.push_back(ne);
      end
    end
    #1;
    check("rd", {59'd0, rd}, {59'd0, m_rd});
    check("write_data", {32'd0, write_data}, {32'd0, m_wd});
    check("write_enable", {63'd0, write_enable}, {63'd0, m_we});
    if (write_enable === 1'b1) begin
      dut_rf[rd] = write_data;
      wr_cnt++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    foreach (dut_rf[i]) dut_rf[i] = '0;
    @(posedge clk);
    #1;

    // reset with a load offered
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h11);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h11);
    check("rst_we", {63'd0, write_enable}, 64'd0);
    check("rst_mask", {32'd0, pending_mask}, 64'd0);
    idle();
    check("post_rst_ready", {63'd0, mem_ready}, 64'd1);

    // ALU only
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("alu_rd", {59'd0, rd}, 64'd5);
    check("alu_data", {32'd0, write_data}, 64'hDEADBEEF);
    check("alu_we", {63'd0, write_enable}, 64'd1);
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    check("alu_x0_we", {63'd0, write_enable}, 64'd0);

    // backpressure while the ALU holds the port
    step(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd3, 32'h333);
    step(1'b0, 1'b1, 5'd1, 32'hA2, 1'b1, 5'd4, 32'h444);
    check("bp_ready_full", {63'd0, mem_ready}, 64'd0);
    check("bp_mask", {32'd0, pending_mask}, 64'h18);
    step(1'b0, 1'b1, 5'd1, 32'hA3, 1'b1, 5'd6, 32'h666);
    idle();
    check("bp_pop3", {59'd0, rd, write_enable}, {58'd0, 5'd3, 1'b1});
    check("bp_mask3", {32'd0, pending_mask}, 64'h10);
    check("bp_ready_back", {63'd0, mem_ready}, 64'd1);
    idle();
    check("bp_pop4", {27'd0, rd, write_data}, {27'd0, 5'd4, 32'h444});
    check("bp_mask_clear", {32'd0, pending_mask}, 64'd0);

    // WAW squash of a queued load
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd1);
    step(1'b0, 1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0);
    check("waw_mask7", {63'd0, pending_mask[7]}, 64'd0);
    idle();
    check("waw_dead_pop", {63'd0, write_enable}, 64'd0);
    check("waw_x7", {32'd0, dut_rf[7]}, 64'd2);

    // same-cycle conflict
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h55);
    check("conf_mask9", {63'd0, pending_mask[9]}, 64'd0);
    idle();
    check("conf_dead_pop", {63'd0, write_enable}, 64'd0);
    check("conf_x9", {32'd0, dut_rf[9]}, 64'h99);

    // wrap-around at full rate
    wr_cnt = 0;
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h1000 + i);
    idle();
    idle();
    check("wrap_writes", 64'(wr_cnt), 64'd10);
    check("wrap_last_rd", {59'd0, rd}, 64'd10);
    for (int i = 1; i <= 10; i++) check("wrap_rf", {32'd0, dut_rf[i]}, 64'h1000 + i);

    // random traffic, including mid-operation resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
